bullet_pool_ctrl: RTL and testbench
===================================

// Module: bullet_pool_ctrl
// PURPOSE
//   Scheduler for the player's bullets. Owns a pool of N_SLOTS bullet slots and grants
//   fire requests to the lowest free slot. Applies a refire cooldown, advances every
//   live bullet upward on each movement tick, and retires slots on hit or screen exit.
//   Sits between player input/position logic, collision logic and the VGA pixel mux.
// PARAMETERS
//   N_SLOTS    4    number of bullet slots (1..8)
//   COOLDOWN   16   movement ticks between granted shots (1..255)
//   SPEED      1    pixels moved upward per tick (1..15)
//   MUZZLE_DX  23   spawn x offset from p_x
//   MUZZLE_DY  40   spawn y offset above p_y
//   BW, BH     10, 40   bullet sprite width/height in pixels
// PORTS
//   clk          in   1         system clock
//   rst          in   1         synchronous reset, active-high
//   tick         in   1         one-cycle movement strobe (frame/slow clock enable)
//   fire         in   1         fire button, level, already synchronised to clk
//   p_x, p_y     in   10        player sprite top-left
//   hit_valid    in   1         collision logic reports a hit this cycle
//   hit_slot     in   3         slot index that hit
//   x, y         in   10        current VGA scan pixel
//   fire_ack     out  1         one-cycle pulse: shot granted
//   pool_full    out  1         all slots active
//   slot_active  out  N_SLOTS   per-slot live flag
//   slot_x       out  10*N_SLOTS  packed x positions, slot i at [10*i +: 10]
//   slot_y       out  10*N_SLOTS  packed y positions, same packing
//   pix_en       out  1         scan pixel lies on a live bullet (1-cycle latency)
//   pix_rgb      out  12        bullet colour, 12'hFFF when pix_en, else 12'h000
// BEHAVIOUR
//   Reset: all slot_active=0, slot_x/slot_y=0, cooldown=0, fire_ack=0, pix_en=0,
//     pix_rgb=0. Reset mid-flight kills all bullets on that edge.
//   Free mask = ~slot_active as registered at the start of the cycle. A slot retired in
//     cycle t is reusable from cycle t+1.
//   Shot request: shot_req per CONFIGURATION. Grant when shot_req && cooldown==0 &&
//     free mask != 0 && p_y >= MUZZLE_DY. Grant: lowest-index free slot gets
//     x=p_x+MUZZLE_DX, y=p_y-MUZZLE_DY, active=1. fire_ack=1 for one cycle.
//     Cooldown loads COOLDOWN. A request that is not granted is dropped, not queued.
//   Spawn x: the sum is computed in 11 bits. If the result is >639, clamp to 639-BW.
//   Cooldown: 8-bit counter. Decrements on tick when nonzero and saturates at 0.
//     A grant and a tick in the same cycle load COOLDOWN; there is no decrement.
//   Movement on tick: each slot active at the start of the cycle does
//     y<=y-SPEED if y>=SPEED; otherwise active<=0 (top-of-screen exit, no wrap).
//     A slot spawned this cycle is not moved this cycle.
//   Hit: hit_valid with hit_slot<N_SLOTS and that slot active -> active<=0 this edge.
//     Hit takes priority over movement. Hits on an inactive or out-of-range slot are ignored.
//   Retired slots keep their last x/y. Consumers must gate on slot_active.
//   pool_full = &slot_active (combinational from registers).
//   Pixel: pix_en registered <= OR over active i of (x>=bx_i && x<bx_i+BW &&
//     y>=by_i && y<by_i+BH). Compares are done in 11 bits so they cannot wrap.
//   The block has no FSM states beyond the per-slot active bits and the cooldown counter.
//     The grant path is a priority encoder plus a one-hot write.
// CONFIGURATION
//   BULLET_AUTOFIRE_EN defined: shot_req = fire (level). Holding fire gives one shot
//     every COOLDOWN ticks while a slot is free.
//   Not defined: shot_req = fire & ~fire_q (rising edge, fire_q reset to 0). Exactly one
//     request per press. A press during cooldown is lost.
// TESTING
//   1 Reset, p=(100,300), pulse fire -> next edge fire_ack=1, slot0 active, x=123, y=260.
//   2 Hold fire, 4 slots, COOLDOWN=2, no hits -> grants fill slots 0..3 in order,
//     pool_full=1, and the 5th request gets no fire_ack.
//   3 Slot0 y=1, SPEED=1, tick -> y=0. Next tick -> slot0 inactive, y stays 0.
//   4 hit_valid, hit_slot=0, tick, and grant all in the same cycle with slot0 the only
//     active slot and slots 1..3 free -> slot0 retired, new bullet in slot1, unmoved.
//   5 Bullet at (123,260), scan x=127, y=279 -> pix_en=1, pix_rgb=FFF one cycle later;
//     x=133 -> pix_en=0.
//   6 Assert rst with 3 live bullets and cooldown 5 -> all inactive and cooldown 0.
//     The next fire press is granted immediately.

Source files
------------

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl
//   Player bullet scheduler. Owns N_SLOTS bullet slots, grants fire requests to the
//   lowest free slot, enforces a refire cooldown counted in movement ticks, moves live
//   bullets upward on each tick, retires slots on hit or top-of-screen exit, and
//   produces a registered pixel-enable/colour for the VGA mux.
//
// Build option: BULLET_AUTOFIRE_EN
//   defined     -> fire is used as a level (autofire while held, paced by the cooldown)
//   not defined -> only a rising edge of fire requests a shot
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   tick                one-cycle movement strobe
//   fire                fire button level (already synchronised)
//   p_x, p_y            player sprite top-left
//   hit_valid, hit_slot collision report (slot index)
//   x, y                current VGA scan pixel
//   fire_ack            one-cycle pulse when a shot is granted
//   pool_full           all slots live
//   slot_active         per-slot live flags
//   slot_x, slot_y      packed positions, slot i at [10*i +: 10]
//   pix_en, pix_rgb     scan pixel on a live bullet (1-cycle latency), colour
module bullet_pool_ctrl #(
  parameter int N_SLOTS   = 4,
  parameter int COOLDOWN  = 16,
  parameter int SPEED     = 1,
  parameter int MUZZLE_DX = 23,
  parameter int MUZZLE_DY = 40,
  parameter int BW        = 10,
  parameter int BH        = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    fire,
  input  logic [9:0]              p_x,
  input  logic [9:0]              p_y,
  input  logic                    hit_valid,
  input  logic [2:0]              hit_slot,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  output logic                    fire_ack,
  output logic                    pool_full,
  output logic [N_SLOTS-1:0]      slot_active,
  output logic [10*N_SLOTS-1:0]   slot_x,
  output logic [10*N_SLOTS-1:0]   slot_y,
  output logic                    pix_en,
  output logic [11:0]             pix_rgb
);

  localparam logic [7:0]  COOL_W  = 8'(COOLDOWN);
  localparam logic [9:0]  SPEED_W = 10'(SPEED);
  localparam logic [10:0] DX_W    = 11'(MUZZLE_DX);
  localparam logic [9:0]  DY_W    = 10'(MUZZLE_DY);
  localparam logic [10:0] BW_W    = 11'(BW);
  localparam logic [10:0] BH_W    = 11'(BH);
  localparam logic [10:0] X_MAX   = 11'd639;
  localparam logic [9:0]  X_CLAMP = 10'(639 - BW);

  logic [N_SLOTS-1:0] active_q, active_d;
  logic [9:0]         sx_q [N_SLOTS];
  logic [9:0]         sx_d [N_SLOTS];
  logic [9:0]         sy_q [N_SLOTS];
  logic [9:0]         sy_d [N_SLOTS];
  logic [7:0]         cool_q, cool_d;
  logic               ack_q, ack_d;
  logic               pix_q, pix_d;

  logic               shot_req;
  logic               grant;
  logic               found;
  logic [N_SLOTS-1:0] free_mask;
  logic [N_SLOTS-1:0] gnt_oh;
  logic [10:0]        spawn_sum;
  logic [9:0]         spawn_x;
  logic [9:0]         spawn_y;

`ifdef BULLET_AUTOFIRE_EN
  assign shot_req = fire;
`else
  logic fire_q, fire_d;
  assign fire_d = fire;
  always_ff @(posedge clk) begin
    if (rst) fire_q <= 1'b0;
    else     fire_q <= fire_d;
  end
  assign shot_req = fire & ~fire_q;
`endif

  // Free mask comes from the registered flags, so a slot retired this cycle
  // only becomes grantable next cycle.
  assign free_mask = ~active_q;

  always_comb begin
    gnt_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (free_mask[i] && !found) begin
        gnt_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign grant     = shot_req && (cool_q == 8'd0) && (|free_mask) && (p_y >= DY_W);
  assign spawn_sum = {1'b0, p_x} + DX_W;
  assign spawn_x   = (spawn_sum > X_MAX) ? X_CLAMP : spawn_sum[9:0];
  assign spawn_y   = p_y - DY_W;

  always_comb begin
    cool_d = cool_q;
    if (grant)                        cool_d = COOL_W;
    else if (tick && cool_q != 8'd0)  cool_d = cool_q - 8'd1;
  end

  assign ack_d = grant;

  // Hit beats movement; a granted slot was free at cycle start so it is never moved
  // on the cycle it spawns.
  always_comb begin
    active_d = active_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (active_q[i]) begin
        if (hit_valid && hit_slot == 3'(i)) begin
          active_d[i] = 1'b0;
        end else if (tick) begin
          if (sy_q[i] >= SPEED_W) sy_d[i] = sy_q[i] - SPEED_W;
          else                    active_d[i] = 1'b0;
        end
      end else if (grant && gnt_oh[i]) begin
        active_d[i] = 1'b1;
        sx_d[i]     = spawn_x;
        sy_d[i]     = spawn_y;
      end
    end
  end

  // 11-bit compares so bx+BW / by+BH cannot wrap near the screen edge.
  always_comb begin
    pix_d = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (active_q[i] &&
          ({1'b0, x} >= {1'b0, sx_q[i]}) && ({1'b0, x} < ({1'b0, sx_q[i]} + BW_W)) &&
          ({1'b0, y} >= {1'b0, sy_q[i]}) && ({1'b0, y} < ({1'b0, sy_q[i]} + BH_W)))
        pix_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      cool_q   <= 8'd0;
      ack_q    <= 1'b0;
      pix_q    <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        sx_q[i] <= 10'd0;
        sy_q[i] <= 10'd0;
      end
    end else begin
      active_q <= active_d;
      cool_q   <= cool_d;
      ack_q    <= ack_d;
      pix_q    <= pix_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
    end
  end

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_x[10*i +: 10] = sx_q[i];
      slot_y[10*i +: 10] = sy_q[i];
    end
  end

  assign fire_ack    = ack_q;
  assign pool_full   = &active_q;
  assign slot_active = active_q;
  assign pix_en      = pix_q;
  assign pix_rgb     = pix_q ? 12'hFFF : 12'h000;

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
module tb_bullet_pool_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst, tick, fire, hit_valid;
  logic [9:0] p_x, p_y, x, y;
  logic [2:0] hit_slot;
  logic fire_ack, pool_full, pix_en;
  logic [N-1:0] slot_active;
  logic [10*N-1:0] slot_x, slot_y;
  logic [11:0] pix_rgb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bullet_pool_ctrl #(.N_SLOTS(N), .COOLDOWN(5), .SPEED(1), .MUZZLE_DX(23),
                     .MUZZLE_DY(40), .BW(10), .BH(40)) dut (
    .clk(clk), .rst(rst), .tick(tick), .fire(fire), .p_x(p_x), .p_y(p_y),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .x(x), .y(y),
    .fire_ack(fire_ack), .pool_full(pool_full), .slot_active(slot_active),
    .slot_x(slot_x), .slot_y(slot_y), .pix_en(pix_en), .pix_rgb(pix_rgb));

  // advance one clock edge, sample 1ns after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; fire = 1'b0; hit_valid = 1'b0; hit_slot = 3'd0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    for (int k = 0; k < n; k++) cyc();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    p_x = 10'd0; p_y = 10'd0; x = 10'd0; y = 10'd0;
    do_reset();
    total++; if (slot_active !== 4'b0000) begin bad++; $display("FAIL reset_active got=%b exp=0000", slot_active); end
    total++; if (slot_x !== 40'd0 || slot_y !== 40'd0) begin bad++; $display("FAIL reset_pos got x=%h y=%h exp=0", slot_x, slot_y); end
    total++; if (fire_ack !== 1'b0 || pix_en !== 1'b0 || pix_rgb !== 12'h000 || pool_full !== 1'b0)
      begin bad++; $display("FAIL reset_outs ack=%b pix=%b rgb=%h full=%b exp=0", fire_ack, pix_en, pix_rgb, pool_full); end
  endtask

  task automatic test_single_fire();
    p_x = 10'd100; p_y = 10'd300;
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b1) begin bad++; $display("FAIL t1_ack got=%b exp=1", fire_ack); end
    total++; if (slot_active !== 4'b0001) begin bad++; $display("FAIL t1_active got=%b exp=0001", slot_active); end
    total++; if (slot_x[9:0] !== 10'd123 || slot_y[9:0] !== 10'd260)
      begin bad++; $display("FAIL t1_pos got=(%0d,%0d) exp=(123,260)", slot_x[9:0], slot_y[9:0]); end
    fire = 1'b0; cyc();
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL t1_ack_pulse got=%b exp=0", fire_ack); end
  endtask

  task automatic test_pixel();
    x = 10'd127; y = 10'd279; cyc();
    total++; if (pix_en !== 1'b1 || pix_rgb !== 12'hFFF) begin bad++; $display("FAIL pix_inside got en=%b rgb=%h exp=1 FFF", pix_en, pix_rgb); end
    x = 10'd133; cyc();
    total++; if (pix_en !== 1'b0 || pix_rgb !== 12'h000) begin bad++; $display("FAIL pix_right_edge got en=%b rgb=%h exp=0 000", pix_en, pix_rgb); end
    x = 10'd132; y = 10'd299; cyc();
    total++; if (pix_en !== 1'b1) begin bad++; $display("FAIL pix_corner got=%b exp=1", pix_en); end
    y = 10'd300; cyc();
    total++; if (pix_en !== 1'b0) begin bad++; $display("FAIL pix_bottom_edge got=%b exp=0", pix_en); end
    x = 10'd122; y = 10'd260; cyc();
    total++; if (pix_en !== 1'b0) begin bad++; $display("FAIL pix_left_edge got=%b exp=0", pix_en); end
    x = 10'd123; cyc();
    total++; if (pix_en !== 1'b1) begin bad++; $display("FAIL pix_top_left got=%b exp=1", pix_en); end
    x = 10'd0; y = 10'd0;
  endtask

  task automatic test_cooldown_drop();
    // cooldown is 5 after the grant in test_single_fire, no ticks since
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b0 || slot_active !== 4'b0001)
      begin bad++; $display("FAIL cd_drop got ack=%b act=%b exp=0 0001", fire_ack, slot_active); end
    fire = 1'b0; cyc();
    ticks(5);
    total++; if (slot_y[9:0] !== 10'd255) begin bad++; $display("FAIL cd_move got=%0d exp=255", slot_y[9:0]); end
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b1 || slot_active !== 4'b0011 || slot_x[19:10] !== 10'd123)
      begin bad++; $display("FAIL cd_regrant got ack=%b act=%b x1=%0d exp=1 0011 123", fire_ack, slot_active, slot_x[19:10]); end
    fire = 1'b0; cyc();
  endtask

  task automatic test_fill();
    logic [3:0] exp_act;
    do_reset();
    p_x = 10'd100; p_y = 10'd300;
    for (int k = 0; k < 4; k++) begin
      total++; if (pool_full !== 1'b0) begin bad++; $display("FAIL fill_notfull_%0d got=%b exp=0", k, pool_full); end
      fire = 1'b1; cyc();
      exp_act = 4'((1 << (k + 1)) - 1);
      total++; if (fire_ack !== 1'b1 || slot_active !== exp_act)
        begin bad++; $display("FAIL fill_grant_%0d got ack=%b act=%b exp=1 %b", k, fire_ack, slot_active, exp_act); end
      fire = 1'b0; cyc();
      if (k < 3) ticks(5);
    end
    total++; if (slot_x[39:30] !== 10'd123 || slot_y[39:30] !== 10'd260)
      begin bad++; $display("FAIL fill_slot3_pos got=(%0d,%0d) exp=(123,260)", slot_x[39:30], slot_y[39:30]); end
    total++; if (pool_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", pool_full); end
    ticks(5);
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b0 || slot_active !== 4'b1111)
      begin bad++; $display("FAIL fill_fifth got ack=%b act=%b exp=0 1111", fire_ack, slot_active); end
    fire = 1'b0; cyc();
  endtask

  task automatic test_move_exit();
    do_reset();
    p_x = 10'd100; p_y = 10'd41;
    fire = 1'b1; cyc();
    fire = 1'b0;
    total++; if (slot_y[9:0] !== 10'd1) begin bad++; $display("FAIL exit_spawn got=%0d exp=1", slot_y[9:0]); end
    ticks(1);
    total++; if (slot_y[9:0] !== 10'd0 || slot_active[0] !== 1'b1)
      begin bad++; $display("FAIL exit_y0 got y=%0d act=%b exp=0 1", slot_y[9:0], slot_active[0]); end
    ticks(1);
    total++; if (slot_active[0] !== 1'b0 || slot_y[9:0] !== 10'd0)
      begin bad++; $display("FAIL exit_retire got act=%b y=%0d exp=0 0", slot_active[0], slot_y[9:0]); end
  endtask

  task automatic test_spawn_limits();
    do_reset();
    p_x = 10'd100; p_y = 10'd39;
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b0 || slot_active !== 4'b0000)
      begin bad++; $display("FAIL spawn_low_py got ack=%b act=%b exp=0 0000", fire_ack, slot_active); end
    fire = 1'b0; cyc();
    p_x = 10'd620; p_y = 10'd40;
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b1 || slot_x[9:0] !== 10'd629 || slot_y[9:0] !== 10'd0)
      begin bad++; $display("FAIL spawn_clamp got ack=%b pos=(%0d,%0d) exp=1 (629,0)", fire_ack, slot_x[9:0], slot_y[9:0]); end
    fire = 1'b0; cyc();
    ticks(5);
    p_x = 10'd616; p_y = 10'd100;
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b1 || slot_active !== 4'b0001 || slot_x[9:0] !== 10'd639)
      begin bad++; $display("FAIL spawn_639 got ack=%b act=%b x=%0d exp=1 0001 639", fire_ack, slot_active, slot_x[9:0]); end
    fire = 1'b0; cyc();
  endtask

  task automatic test_hit_same_cycle();
    do_reset();
    p_x = 10'd100; p_y = 10'd300;
    fire = 1'b1; cyc();
    fire = 1'b0; cyc();
    ticks(5);
    fire = 1'b1; tick = 1'b1; hit_valid = 1'b1; hit_slot = 3'd0;
    cyc();
    fire = 1'b0; tick = 1'b0; hit_valid = 1'b0;
    total++; if (fire_ack !== 1'b1 || slot_active !== 4'b0010)
      begin bad++; $display("FAIL hit_combo got ack=%b act=%b exp=1 0010", fire_ack, slot_active); end
    total++; if (slot_y[19:10] !== 10'd260 || slot_x[19:10] !== 10'd123)
      begin bad++; $display("FAIL hit_combo_pos got=(%0d,%0d) exp=(123,260)", slot_x[19:10], slot_y[19:10]); end
    hit_valid = 1'b1; hit_slot = 3'd5; cyc();
    total++; if (slot_active !== 4'b0010) begin bad++; $display("FAIL hit_range got=%b exp=0010", slot_active); end
    hit_slot = 3'd2; cyc();
    total++; if (slot_active !== 4'b0010) begin bad++; $display("FAIL hit_inactive got=%b exp=0010", slot_active); end
    hit_slot = 3'd1; cyc();
    hit_valid = 1'b0;
    total++; if (slot_active !== 4'b0000) begin bad++; $display("FAIL hit_kill got=%b exp=0000", slot_active); end
    // grant+tick loaded cooldown 5 without decrement: 4 ticks leave 1
    ticks(4);
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b0) begin bad++; $display("FAIL cd_load_nodec got=%b exp=0", fire_ack); end
    fire = 1'b0; cyc();
    ticks(1);
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b1) begin bad++; $display("FAIL cd_expire got=%b exp=1", fire_ack); end
    fire = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    p_x = 10'd100; p_y = 10'd300;
    for (int k = 0; k < 3; k++) begin
      fire = 1'b1; cyc();
      fire = 1'b0; cyc();
      if (k < 2) ticks(5);
    end
    total++; if (slot_active !== 4'b0111) begin bad++; $display("FAIL mid_pre got=%b exp=0111", slot_active); end
    rst = 1'b1; cyc();
    rst = 1'b0;
    total++; if (slot_active !== 4'b0000 || fire_ack !== 1'b0)
      begin bad++; $display("FAIL mid_reset got act=%b ack=%b exp=0000 0", slot_active, fire_ack); end
    fire = 1'b1; cyc();
    total++; if (fire_ack !== 1'b1 || slot_active !== 4'b0001)
      begin bad++; $display("FAIL mid_regrant got ack=%b act=%b exp=1 0001", fire_ack, slot_active); end
    fire = 1'b0; cyc();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; fire = 1'b0; hit_valid = 1'b0; hit_slot = 3'd0;
    p_x = 10'd0; p_y = 10'd0; x = 10'd0; y = 10'd0;
    test_reset();
    test_single_fire();
    test_pixel();
    test_cooldown_drop();
    test_fill();
    test_move_exit();
    test_spawn_limits();
    test_hit_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
